// File: rtl/ft245_cmd_ctrl_if.sv
// FT245-style byte stream between the command controller and the FIFO front end.
// master = command controller, slave = FIFO front end.
interface ft245_cmd_ctrl_if;
  logic       ft_rx_req;
  logic       ft_rx_valid;
  logic [7:0] ft_rx_byte;
  logic       ft_tx_req;
  logic [7:0] ft_tx_byte;
  logic       ft_tx_ack;

  modport master (
    output ft_rx_req,
    output ft_tx_req,
    output ft_tx_byte,
    input  ft_rx_valid,
    input  ft_rx_byte,
    input  ft_tx_ack
  );

  modport slave (
    input  ft_rx_req,
    input  ft_tx_req,
    input  ft_tx_byte,
    output ft_rx_valid,
    output ft_rx_byte,
    output ft_tx_ack
  );
endinterface

// File: rtl/ft245_cmd_ctrl.sv
// Byte-oriented register access controller behind an FT245-style FIFO.
// Frames: header [7]=write, [6:4]=reserved (0), [3:0]=address; write frames add a data byte.
// Every accepted frame produces exactly one response byte (0x5A ack, read data or 0xEE reject).
module ft245_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  ft245_cmd_ctrl_if.master        ft,
  input  logic [31:0]             status_in,
  output logic [95:0]             reg_out,
  output logic                    wr_strobe,
  output logic [3:0]              wr_addr,
  output logic                    err_flag
);

  // Counter holds 0..TIMEOUT_CYCLES-1 idle cycles spent in StGetData.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] RespAck    = 8'h5A;
  localparam logic [7:0] RespReject = 8'hEE;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGetData = 2'd1,
    StExec    = 2'd2,
    StSend    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [7:0]        data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [95:0]       regs_q, regs_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [3:0]        wr_addr_q, wr_addr_d;
  logic              err_q, err_d;

  logic              hdr_is_wr;
  logic              hdr_rsvd_ok;
  logic [3:0]        hdr_addr;
  logic              hdr_addr_ro;
  logic [7:0]        rd_value;

  assign hdr_is_wr   = hdr_q[7];
  assign hdr_rsvd_ok = (hdr_q[6:4] == 3'b000);
  assign hdr_addr    = hdr_q[3:0];
  assign hdr_addr_ro = (hdr_addr >= 4'd12);

  // Read data mux: addresses 0..11 from the R/W bank, 12..15 from status_in.
  always_comb begin
    rd_value = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (hdr_addr == 4'(i)) rd_value = regs_q[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      if (hdr_addr == 4'(12 + i)) rd_value = status_in[8*i +: 8];
    end
  end

  // Next-state, frame capture, register write and error tracking.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    tx_byte_d   = tx_byte_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_d       = err_q;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ft.ft_rx_valid) begin
          hdr_d   = ft.ft_rx_byte;
          state_d = ft.ft_rx_byte[7] ? StGetData : StExec;
        end
      end
      StGetData: begin
        if (ft.ft_rx_valid) begin
          data_d  = ft.ft_rx_byte;
          state_d = StExec;
        end else if (cnt_q == CntLast) begin
          // Second byte never came: drop the frame silently apart from the flag.
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        if (!hdr_rsvd_ok || (hdr_is_wr && hdr_addr_ro)) begin
          tx_byte_d = RespReject;
          err_d     = 1'b1;
        end else if (hdr_is_wr) begin
          for (int i = 0; i < 12; i++) begin
            if (hdr_addr == 4'(i)) regs_d[8*i +: 8] = data_q;
          end
          wr_strobe_d = 1'b1;
          wr_addr_d   = hdr_addr;
          tx_byte_d   = RespAck;
        end else begin
          tx_byte_d = rd_value;
        end
        if (ft.ft_rx_valid) err_d = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (ft.ft_rx_valid) err_d = 1'b1;
        if (ft.ft_tx_ack) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hdr_q       <= 8'h00;
      data_q      <= 8'h00;
      cnt_q       <= '0;
      tx_byte_q   <= 8'h00;
      regs_q      <= 96'h0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      tx_byte_q   <= tx_byte_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
    end
  end

  assign ft.ft_rx_req  = (state_q == StIdle) || (state_q == StGetData);
  assign ft.ft_tx_req  = (state_q == StSend);
  assign ft.ft_tx_byte = tx_byte_q;
  assign reg_out       = regs_q;
  assign wr_strobe     = wr_strobe_q;
  assign wr_addr       = wr_addr_q;
  assign err_flag      = err_q;

endmodule

// File: tb/tb_ft245_cmd_ctrl.sv
// Directed self-checking bench for ft245_cmd_ctrl (TIMEOUT_CYCLES = 16).
module tb_ft245_cmd_ctrl;
  logic        clk;
  logic        reset;
  logic [31:0] status_in;
  logic [95:0] reg_out;
  logic        wr_strobe;
  logic [3:0]  wr_addr;
  logic        err_flag;

  int tests_run;
  int tests_failed;
  logic [95:0] exp_reg;

  ft245_cmd_ctrl_if ft_if ();

  ft245_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .ft        (ft_if),
    .status_in (status_in),
    .reg_out   (reg_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .err_flag  (err_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ft_if.ft_rx_byte  = b;
    ft_if.ft_rx_valid = 1'b1;
    tick();
    ft_if.ft_rx_valid = 1'b0;
  endtask

  task automatic send_ack();
    ft_if.ft_tx_ack = 1'b1;
    tick();
    ft_if.ft_tx_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_reg = 96'h0;
    tick();
  endtask

  // Leaves the bench in the first SEND cycle.
  task automatic frame_wr(input logic [7:0] hdr, input logic [7:0] data);
    send_byte(hdr);
    send_byte(data);
    tick();
  endtask

  task automatic frame_rd(input logic [7:0] hdr);
    send_byte(hdr);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++; if (ft_if.ft_tx_req !== 1'b0) begin tests_failed++;
      $display("FAIL rst_tx_req: got %b want 0", ft_if.ft_tx_req); end
    tests_run++; if (ft_if.ft_tx_byte !== 8'h00) begin tests_failed++;
      $display("FAIL rst_tx_byte: got %h want 00", ft_if.ft_tx_byte); end
    tests_run++; if (reg_out !== 96'h0) begin tests_failed++;
      $display("FAIL rst_reg_out: got %h want 0", reg_out); end
    tests_run++; if ({wr_strobe, wr_addr, err_flag} !== 6'b0) begin tests_failed++;
      $display("FAIL rst_misc: got %b want 000000", {wr_strobe, wr_addr, err_flag}); end
    reset = 1'b0;
    exp_reg = 96'h0;
    tick();
    tests_run++; if (ft_if.ft_rx_req !== 1'b1) begin tests_failed++;
      $display("FAIL rst_rx_req: got %b want 1", ft_if.ft_rx_req); end
  endtask

  task automatic test_write();
    send_byte(8'h83);
    tests_run++; if ({ft_if.ft_rx_req, ft_if.ft_tx_req} !== 2'b10) begin tests_failed++;
      $display("FAIL wr_getdata: got %b want 10", {ft_if.ft_rx_req, ft_if.ft_tx_req}); end
    send_byte(8'h3C);
    tests_run++; if ({ft_if.ft_rx_req, ft_if.ft_tx_req, wr_strobe} !== 3'b000) begin
      tests_failed++;
      $display("FAIL wr_exec: got %b want 000", {ft_if.ft_rx_req, ft_if.ft_tx_req, wr_strobe});
    end
    tick();
    exp_reg[31:24] = 8'h3C;
    tests_run++; if ({ft_if.ft_tx_req, wr_strobe, wr_addr} !== 6'b11_0011) begin tests_failed++;
      $display("FAIL wr_strobe: got %b want 110011", {ft_if.ft_tx_req, wr_strobe, wr_addr}); end
    tests_run++; if (ft_if.ft_tx_byte !== 8'h5A) begin tests_failed++;
      $display("FAIL wr_tx_byte: got %h want 5a", ft_if.ft_tx_byte); end
    tests_run++; if (reg_out !== exp_reg) begin tests_failed++;
      $display("FAIL wr_reg_out: got %h want %h", reg_out, exp_reg); end
    tick();
    tests_run++; if ({wr_strobe, ft_if.ft_tx_req} !== 2'b01) begin tests_failed++;
      $display("FAIL wr_strobe_pulse: got %b want 01", {wr_strobe, ft_if.ft_tx_req}); end
    send_ack();
    tests_run++; if ({ft_if.ft_rx_req, ft_if.ft_tx_req, err_flag} !== 3'b100) begin
      tests_failed++;
      $display("FAIL wr_ack_idle: got %b want 100", {ft_if.ft_rx_req, ft_if.ft_tx_req, err_flag});
    end
  endtask

  task automatic test_read();
    logic [7:0] hdrs [4];
    logic [7:0] exps [4];
    hdrs = '{8'h03, 8'h0D, 8'h0C, 8'h0F};
    exps = '{8'h3C, 8'hCC, 8'hDD, 8'hAA};
    status_in = 32'hAABBCCDD;
    for (int i = 0; i < 4; i++) begin
      send_byte(hdrs[i]);
      tests_run++; if ({ft_if.ft_rx_req, ft_if.ft_tx_req} !== 2'b00) begin tests_failed++;
        $display("FAIL rd_exec[%0d]: got %b want 00", i, {ft_if.ft_rx_req, ft_if.ft_tx_req}); end
      tick();
      tests_run++; if (ft_if.ft_tx_byte !== exps[i] || ft_if.ft_tx_req !== 1'b1) begin
        tests_failed++;
        $display("FAIL rd_data[%0d]: got %h req %b want %h req 1", i, ft_if.ft_tx_byte,
                 ft_if.ft_tx_req, exps[i]);
      end
      tests_run++; if (wr_strobe !== 1'b0 || reg_out !== exp_reg) begin tests_failed++;
        $display("FAIL rd_no_write[%0d]: got strobe %b regs %h want 0 %h", i, wr_strobe,
                 reg_out, exp_reg);
      end
      send_ack();
    end
  endtask

  task automatic test_back_to_back();
    frame_wr(8'h80, 8'h11);
    exp_reg[7:0] = 8'h11;
    send_ack();
    tests_run++; if (ft_if.ft_rx_req !== 1'b1) begin tests_failed++;
      $display("FAIL b2b_rx_req: got %b want 1", ft_if.ft_rx_req); end
    frame_wr(8'h8B, 8'h99);
    exp_reg[95:88] = 8'h99;
    tests_run++; if ({ft_if.ft_tx_byte, wr_strobe, wr_addr} !== {8'h5A, 1'b1, 4'hB}) begin
      tests_failed++;
      $display("FAIL b2b_wr11: got %h/%b/%h want 5a/1/b", ft_if.ft_tx_byte, wr_strobe, wr_addr);
    end
    tests_run++; if (reg_out !== exp_reg) begin tests_failed++;
      $display("FAIL b2b_reg_out: got %h want %h", reg_out, exp_reg); end
    send_ack();
    frame_rd(8'h00);
    tests_run++; if (ft_if.ft_tx_byte !== 8'h11) begin tests_failed++;
      $display("FAIL b2b_rd0: got %h want 11", ft_if.ft_tx_byte); end
    send_ack();
    frame_rd(8'h0B);
    tests_run++; if (ft_if.ft_tx_byte !== 8'h99) begin tests_failed++;
      $display("FAIL b2b_rd11: got %h want 99", ft_if.ft_tx_byte); end
    send_ack();
  endtask

  task automatic test_reject();
    tests_run++; if (err_flag !== 1'b0) begin tests_failed++;
      $display("FAIL rej_err_before: got %b want 0", err_flag); end
    frame_wr(8'h8E, 8'h11);
    tests_run++; if (ft_if.ft_tx_byte !== 8'hEE || wr_strobe !== 1'b0) begin tests_failed++;
      $display("FAIL rej_wr_ro: got %h strobe %b want ee 0", ft_if.ft_tx_byte, wr_strobe); end
    tests_run++; if (reg_out !== exp_reg || err_flag !== 1'b1) begin tests_failed++;
      $display("FAIL rej_wr_state: got %h err %b want %h 1", reg_out, err_flag, exp_reg); end
    send_ack();
    frame_rd(8'h43);
    tests_run++; if (ft_if.ft_tx_byte !== 8'hEE || reg_out !== exp_reg) begin tests_failed++;
      $display("FAIL rej_rsvd: got %h regs %h want ee %h", ft_if.ft_tx_byte, reg_out, exp_reg);
    end
    send_ack();
    tests_run++; if (err_flag !== 1'b1) begin tests_failed++;
      $display("FAIL rej_err_sticky: got %b want 1", err_flag); end
  endtask

  task automatic test_timeout();
    do_reset();
    frame_wr(8'h81, 8'h42);
    exp_reg[15:8] = 8'h42;
    send_ack();
    tests_run++; if (err_flag !== 1'b0) begin tests_failed++;
      $display("FAIL to_err_before: got %b want 0", err_flag); end
    send_byte(8'h81);
    for (int i = 0; i < 15; i++) begin
      tick();
      tests_run++; if (ft_if.ft_tx_req !== 1'b0 || ft_if.ft_rx_req !== 1'b1) begin
        tests_failed++;
        $display("FAIL to_wait[%0d]: got tx %b rx %b want 0 1", i, ft_if.ft_tx_req,
                 ft_if.ft_rx_req);
      end
    end
    tests_run++; if (err_flag !== 1'b0) begin tests_failed++;
      $display("FAIL to_early: got %b want 0", err_flag); end
    tick();
    tests_run++; if (err_flag !== 1'b1 || ft_if.ft_tx_req !== 1'b0) begin tests_failed++;
      $display("FAIL to_expire: got err %b tx %b want 1 0", err_flag, ft_if.ft_tx_req); end
    frame_rd(8'h01);
    tests_run++; if (ft_if.ft_tx_byte !== 8'h42 || reg_out !== exp_reg) begin tests_failed++;
      $display("FAIL to_next_rd: got %h regs %h want 42 %h", ft_if.ft_tx_byte, reg_out, exp_reg);
    end
    send_ack();
  endtask

  task automatic test_drop();
    do_reset();
    frame_wr(8'h82, 8'hA5);
    exp_reg[23:16] = 8'hA5;
    tests_run++; if (ft_if.ft_tx_byte !== 8'h5A || err_flag !== 1'b0) begin tests_failed++;
      $display("FAIL drop_pre: got %h err %b want 5a 0", ft_if.ft_tx_byte, err_flag); end
    send_byte(8'h03);
    for (int i = 0; i < 9; i++) begin
      tests_run++; if (ft_if.ft_tx_req !== 1'b1 || ft_if.ft_tx_byte !== 8'h5A) begin
        tests_failed++;
        $display("FAIL drop_hold[%0d]: got req %b byte %h want 1 5a", i, ft_if.ft_tx_req,
                 ft_if.ft_tx_byte);
      end
      tick();
    end
    tests_run++; if (err_flag !== 1'b1) begin tests_failed++;
      $display("FAIL drop_send_err: got %b want 1", err_flag); end
    send_ack();
    tests_run++; if ({ft_if.ft_rx_req, ft_if.ft_tx_req} !== 2'b10) begin tests_failed++;
      $display("FAIL drop_ack: got %b want 10", {ft_if.ft_rx_req, ft_if.ft_tx_req}); end
    frame_rd(8'h02);
    tests_run++; if (ft_if.ft_tx_byte !== 8'hA5) begin tests_failed++;
      $display("FAIL drop_rd: got %h want a5", ft_if.ft_tx_byte); end
    send_ack();
    // Byte arriving while the frame is executing.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h07);
    tests_run++; if ({ft_if.ft_tx_req, err_flag} !== 2'b11 || ft_if.ft_tx_byte !== 8'h00) begin
      tests_failed++;
      $display("FAIL drop_exec: got req/err %b byte %h want 11 00", {ft_if.ft_tx_req, err_flag},
               ft_if.ft_tx_byte);
    end
    send_ack();
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    frame_wr(8'h85, 8'h77);
    send_ack();
    frame_rd(8'h43);
    send_ack();
    send_byte(8'h84);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_reg = 96'h0;
    tests_run++; if (reg_out !== 96'h0 || err_flag !== 1'b0) begin tests_failed++;
      $display("FAIL mid_rst_regs: got %h err %b want 0 0", reg_out, err_flag); end
    tests_run++; if ({ft_if.ft_tx_req, ft_if.ft_tx_byte, wr_strobe, wr_addr} !== 14'h0) begin
      tests_failed++;
      $display("FAIL mid_rst_outs: got %h want 0",
               {ft_if.ft_tx_req, ft_if.ft_tx_byte, wr_strobe, wr_addr});
    end
    tick();
    tests_run++; if (ft_if.ft_rx_req !== 1'b1) begin tests_failed++;
      $display("FAIL mid_rst_rx_req: got %b want 1", ft_if.ft_rx_req); end
    send_ack();
    tests_run++; if (ft_if.ft_tx_req !== 1'b0) begin tests_failed++;
      $display("FAIL mid_rst_late_ack: got %b want 0", ft_if.ft_tx_req); end
    // If the aborted frame survived, 0x04 would be taken as write data (0x5A response).
    frame_rd(8'h04);
    tests_run++; if (ft_if.ft_tx_byte !== 8'h00 || wr_strobe !== 1'b0) begin tests_failed++;
      $display("FAIL mid_rst_idle: got %h strobe %b want 00 0", ft_if.ft_tx_byte, wr_strobe);
    end
    send_ack();
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    exp_reg           = 96'h0;
    reset             = 1'b1;
    status_in         = 32'h0;
    ft_if.ft_rx_valid = 1'b0;
    ft_if.ft_rx_byte  = 8'h00;
    ft_if.ft_tx_ack   = 1'b0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reject();
    test_timeout();
    test_drop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
